uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the UART path. It supports configurable data width, optional odd/even parity, one or two stop bits and a configurable oversampling ratio. A one-entry holding register lets the next byte be accepted during a transmission, so consecutive frames go out with no idle gap. It sits between the upstream byte source (valid/ready handshake) and the TXD pin, and uses the same shared baud tick as the receiver.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- OVERSAMPLE, 16, ticks per bit; legal range 2..64
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous and active-low
- tick_i  in  1  baud×OVERSAMPLE enable, one clk_i cycle wide
- valid_i  in  1  upstream has data on data_i
- data_i  in  DATA_BITS  byte to send, LSB transmitted first
- ready_o  out  1  holding register empty; transfer occurs when valid_i && ready_o on a clk_i edge
- txd_o  out  1  serial line, idle high, registered
- busy_o  out  1  a frame is on the line (state != IDLE)
- done_o  out  1  one-cycle pulse at the end of each frame's last stop bit

## Operation
- Reset (asynchronous assertion, synchronous release) values: txd_o=1, ready_o=1, busy_o=0, done_o=0, holding register empty, state IDLE, all counters 0.
- Holding register:
  - Loads data_i on valid_i && ready_o.
  - ready_o = !hold_full, registered, so it falls in the cycle after acceptance.
  - The register is freed in the same cycle its contents move to the shift register.
  - If a load and a free happen in the same cycle, the register stays full with the new data.
- States: IDLE, START, DATA, PAR, STOP.
  - IDLE: txd_o=1. On a cycle with tick_i && hold_full, move hold into the shift register, free the hold, go to START with tick_cnt=0.
  - START: txd_o=0.
  - DATA: txd_o = shift[0]. The shift register moves right at each bit end. Runs for DATA_BITS bits, tracked by bit_cnt.
  - PAR: entered only if PARITY != 0.
    - Even: parity bit = XOR of the data bits.
    - Odd: parity bit = its inverse.
  - STOP: txd_o=1 for STOP_BITS bit periods.
- Bit end: a tick_i while tick_cnt == OVERSAMPLE-1. tick_cnt then wraps to 0 and the FSM moves to the next bit or state.
  - Ticks are counted only in non-IDLE states.
  - The launch tick in IDLE is not counted.
- Last stop-bit end:
  - done_o pulses for that cycle.
  - If hold_full, the next frame launches on this same tick: state goes to START, txd_o goes 0 next cycle, no idle ticks.
  - Otherwise the FSM returns to IDLE.
- Parity is computed from the data when it is loaded into the shift register, not from the live shift register.
- Counter widths: tick_cnt is $clog2(OVERSAMPLE) bits, bit_cnt is 4 bits. No overflow is possible within legal parameters.
- Illegal parameter values are rejected at elaboration.

## Timing
- Latency: from the launch tick to the first txd_o=0 is one clk_i cycle.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × OVERSAMPLE ticks after the launch tick.
- txd_o, busy_o and done_o are registered with no combinational path from inputs.
- Minimum acceptance spacing: one accept per frame once the hold is full. While both hold and shift registers are occupied, ready_o stays low.
- valid_i without ready_o: the upstream holds data_i stable. No data is dropped or duplicated.
- tick_i with no data: IDLE stays IDLE and txd_o stays 1.
- Reset mid-frame: txd_o returns to 1 immediately (asynchronous). Any partially sent frame and any held byte are discarded. No done_o is produced.

## Test plan
- DATA_BITS=8, PARITY=0, STOP_BITS=1, OVERSAMPLE=16, tick_i every cycle, send 0xA5 → txd_o bits 0,1,0,1,0,0,1,0,1,1. Each bit lasts exactly 16 cycles. done_o pulses once, 160 cycles after the launch tick.
- PARITY=2, send 0x07 → parity bit 1. PARITY=1, send 0x07 → parity bit 0. Parity bit appears between the last data bit and the stop bit.
- STOP_BITS=2, DATA_BITS=5, send 0x1F → 5 ones followed by 2×OVERSAMPLE high ticks. busy_o falls the cycle after done_o.
- Back-to-back: offer 0x55, 0xAA, 0x0F with valid_i held high → the third byte waits with ready_o=0 until the first frame ends. Three frames go out with the start bit immediately following each stop bit and zero idle ticks.
- Sparse tick_i (1 in 5 cycles), send 0x3C → bit periods are 16 ticks (80 cycles) and no transitions occur between ticks.
- Assert rst_n_i low in the middle of data bit 3 with a held byte pending → txd_o=1 and ready_o=1 at once. After release, no frame starts until a new accept.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: configurable width, parity and stop bits,
// with a one-entry holding register for gap-free back-to-back frames.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 tick_i,
  input  logic                 valid_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 ready_o,
  output logic                 txd_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TLAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 2 || OVERSAMPLE > 64) begin : g_bad_oversample
    $error("uart_tx_frame: OVERSAMPLE must be 2..64");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  par_q, par_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  bit_end;
  logic                  launch;

  assign accept  = valid_i && !hold_full_q;
  assign bit_end = tick_i && (state_q != IDLE) &&
                   (tick_cnt_q == TLAST);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    done_d     = 1'b0;
    launch     = 1'b0;

    if (state_q != IDLE && tick_i) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (tick_i && hold_full_q) launch = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == DLAST) begin
            state_d   = (PARITY != 0) ? PAR : STOP;
            bit_cnt_d = '0;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == SLAST) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            if (hold_full_q) launch = 1'b1;
            else state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // parity is fixed at load time, not tracked from the shifting data
    if (launch) begin
      state_d    = START;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = hold_q;
      par_d      = (PARITY == 1) ? ~^hold_q : ^hold_q;
    end

    hold_d      = accept ? data_i : hold_q;
    hold_full_d = accept ? 1'b1 : (launch ? 1'b0 : hold_full_q);
    busy_d      = (state_q != IDLE);

    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PAR:     txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ready_o = !hold_full_q;
  assign txd_o   = txd_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
